// File: rtl/tmr_error_pkg.sv
// Shared definitions for the TMR error collector: readout FSM states and
// the default event-counter width.
package tmr_error_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } rd_state_e;

endpackage

// File: rtl/tmr_error_popcount.sv
// Combinational population count of an N-bit vector.
module tmr_error_popcount #(
    parameter int N = 10
) (
    input  logic [N-1:0]             bits_i,
    output logic [$clog2(N+1)-1:0]   count_o
);

    localparam int PW = $clog2(N + 1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + PW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/tmr_error_collector.sv
// Collects per-instance TMR voter-mismatch flags into sticky bits and a
// saturating rise counter, with a snapshot-and-clear readout handshake.
module tmr_error_collector
    import tmr_error_pkg::*;
#(
    parameter int N     = 10,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     tmr_error_i,
    input  logic [CNT_W-1:0] thr_i,
    input  logic             rd_req_i,
    input  logic             rd_ack_i,
    output logic             err_any_o,
    output logic             rd_valid_o,
    output logic [N-1:0]     rd_flags_o,
    output logic [CNT_W-1:0] rd_count_o,
    output logic             irq_o
);

    localparam int PW = $clog2(N + 1);
    // One spare bit above the wider operand so the sum never wraps before saturation.
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [N-1:0]     q_q, qd_q, sticky_q, sticky_d, rd_flags_q, rd_flags_d;
    logic [CNT_W-1:0] count_q, count_d, rd_count_q, rd_count_d, count_sat;
    logic             irq_q, irq_d;
    rd_state_e        state_q, state_d;
    logic [N-1:0]     rise;
    logic [PW-1:0]    pop;
    logic [SW-1:0]    sum;

    assign rise = q_q & ~qd_q;

    tmr_error_popcount #(.N(N)) u_popcount (
        .bits_i  (rise),
        .count_o (pop)
    );

    always_comb begin
        sum        = SW'(count_q) + SW'(pop);
        count_sat  = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        state_d    = state_q;
        sticky_d   = sticky_q | rise;
        count_d    = count_sat;
        rd_flags_d = rd_flags_q;
        rd_count_d = rd_count_q;
        case (state_q)
            ST_IDLE: begin
                // Snapshot includes this cycle's rises so nothing falls between copy and clear.
                if (rd_req_i) begin
                    state_d    = ST_HOLD;
                    rd_flags_d = sticky_q | rise;
                    rd_count_d = count_sat;
                    sticky_d   = '0;
                    count_d    = '0;
                end
            end
            ST_HOLD: begin
                if (rd_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        irq_d = (thr_i != '0) && (count_d >= thr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= '0;
            qd_q       <= '0;
            sticky_q   <= '0;
            count_q    <= '0;
            irq_q      <= 1'b0;
            state_q    <= ST_IDLE;
            rd_flags_q <= '0;
            rd_count_q <= '0;
        end else begin
            q_q        <= tmr_error_i;
            qd_q       <= q_q;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
            irq_q      <= irq_d;
            state_q    <= state_d;
            rd_flags_q <= rd_flags_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign err_any_o  = |q_q;
    assign rd_valid_o = (state_q == ST_HOLD);
    assign rd_flags_o = rd_flags_q;
    assign rd_count_o = rd_count_q;
    assign irq_o      = irq_q;

endmodule
